// File: rtl/shared_reg_sched_pkg.sv
// Shared types and constants for the shared_reg_sched block.
//   state_t     : scheduler FSM state
//   DEF_*       : default parameter values for the top level
//   SWEEP_LEN_W : width of the sweep length / sweep index
package shared_reg_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 1;
  localparam int DEF_CNT_W   = 32;
  localparam int SWEEP_LEN_W = 8;

endpackage

// File: rtl/shared_reg_sched_if.sv
// Request bus between the requesters and the shared register scheduler.
//   req_valid : per-requester write request
//   req_data  : write data, requester i uses bits [i*WIDTH +: WIDTH]
//   req_ready : one-hot grant, a transfer happens when valid & ready
interface shared_reg_sched_if
  import shared_reg_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/shared_reg_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   last      : index of the previously granted requester
//   grant     : one-hot grant, search starts at last+1 mod NREQ
//   grant_idx : index of the granted requester (0 when nothing granted)
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_reg_sched.sv
// Shared register scheduler: round-robin write arbitration plus a
// self-sweep sequencer, with a saturating count of value changes.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   bus           : requester bus (valid/data in, one-hot ready out)
//   sweep_start   : start a sweep of sweep_len writes (sampled in IDLE)
//   sweep_busy    : high while sweeping
//   sweep_done    : one-cycle pulse after the last sweep write
//   x_out         : shared register
//   change_count  : saturating count of writes that changed x_out
//   last_grant    : index of the last granted requester
//
// state | meaning
// IDLE  | arbitrating requests, or accepting a sweep_start
// SWEEP | writing index 0..L-1 into x_out, requests blocked
module shared_reg_sched
  import shared_reg_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  shared_reg_sched_if.slave      bus,
  input  logic                   sweep_start,
  input  logic [SWEEP_LEN_W-1:0] sweep_len,
  output logic                   sweep_busy,
  output logic                   sweep_done,
  output logic [WIDTH-1:0]       x_out,
  output logic [CNT_W-1:0]       change_count,
  output logic [IDX_W-1:0]       last_grant
);

  state_t                 state_q, state_d;
  logic [SWEEP_LEN_W-1:0] idx_q, idx_d;
  logic [SWEEP_LEN_W-1:0] len_q, len_d;
  logic                   done_d;
  logic                   wr_en;
  logic [WIDTH-1:0]       wr_data;
  logic                   arb_en;
  logic [NREQ-1:0]        grant;
  logic [IDX_W-1:0]       grant_idx;

  // Kept outside the FSM block so the arbiter sits between two separate
  // combinational processes rather than looping through one.
  assign arb_en = (state_q == IDLE) && !sweep_start;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (bus.req_valid & {NREQ{arb_en}}),
    .last      (last_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;
  assign sweep_busy    = (state_q == SWEEP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_data = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
    case (state_q)
      IDLE: begin
        if (sweep_start) begin
          if (sweep_len != '0) begin
            state_d = SWEEP;
            idx_d   = '0;
            len_d   = sweep_len;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          wr_en = |grant;
        end
      end
      SWEEP: begin
        wr_en   = 1'b1;
        wr_data = WIDTH'(idx_q);
        idx_d   = idx_q + 1'b1;
        if (idx_q + 1'b1 == len_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      sweep_done   <= 1'b0;
      x_out        <= '0;
      change_count <= '0;
      last_grant   <= IDX_W'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      sweep_done <= done_d;
      if (wr_en) begin
        x_out <= wr_data;
        if (wr_data != x_out && change_count != '1)
          change_count <= change_count + 1'b1;
      end
      if (|grant)
        last_grant <= grant_idx;
    end
  end

endmodule

// File: doc/shared_reg_sched.md
# shared_reg_sched

Scheduler that owns a single shared WIDTH-bit register and arbitrates write access to it among NREQ requesters, with a built-in sweep sequencer that drives the register through 0..L-1 on its own. It also keeps a saturating count of value changes on the register. It sits between the stimulus agents of a diagnostic and the register they share, so each write is serialized and every value change is counted exactly once.

## Interface
- NREQ, 4: number of requesters (2..16)
- WIDTH, 1: shared register width
- CNT_W, 32: change-counter width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester write request
- req_data  in  NREQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot grant (combinational); transfer when valid & ready
- sweep_start  in  1  start self-sweep (sampled only in IDLE)
- sweep_len  in  8  number of sweep writes L
- sweep_busy  out  1  high while in SWEEP
- sweep_done  out  1  one-cycle pulse at end of sweep
- x_out  out  WIDTH  shared register value
- change_count  out  CNT_W  number of writes that changed x_out
- last_grant  out  $clog2(NREQ)  index of last granted requester

## Operation
- Reset values: x_out=0, change_count=0, sweep_busy=0, sweep_done=0, last_grant=NREQ-1 (so requester 0 wins first), state IDLE, sweep index 0.
- States: IDLE, SWEEP.
- IDLE, sweep_start=1, sweep_len>0: go SWEEP, index←0; requests ignored that cycle (req_ready all 0). Sweep has priority over requests.
- IDLE, sweep_start=1, sweep_len=0: stay IDLE, no write, sweep_done pulses next cycle.
- IDLE otherwise: round-robin among asserted req_valid, search starting at last_grant+1 mod NREQ; winner's req_ready=1, others 0. On that edge x_out←winner data, last_grant←winner.
- SWEEP: each cycle write x_out←index[WIDTH-1:0], index++. req_ready all 0. After write number L, return to IDLE and pulse sweep_done.
- sweep_len is latched at start; changes during SWEEP are ignored.
- Change counter: on every write edge, if new value != current x_out, change_count++; saturates at all-ones. Writes of equal value do not count.
- Reset mid-sweep aborts immediately: all outputs return to reset values, no sweep_done.

## Timing
- Grant combinational in same cycle as req_valid; x_out, change_count, last_grant update on the next rising edge.
- Back-to-back grants every cycle; a requester held valid continuously is served once per NREQ cycles when all requesters are active.
- sweep_start sampled at edge t → writes at edges t+1..t+L; at edge t+L state→IDLE, sweep_done=1 for the cycle following edge t+L, sweep_busy=1 from after edge t until edge t+L.
- First request can be granted in the cycle sweep_done is high.
- Sweep index wraps modulo 2^WIDTH in x_out (e.g. WIDTH=1: 0,1,0,1).

## Structure
- Package shared_reg_sched_pkg: state enum (IDLE, SWEEP), default parameter constants, sweep_len width constant (8).
- Sub-module rr_arbiter: NREQ-wide round-robin grant from request vector and last_grant pointer; purely combinational, instantiated once.
- Top holds state FSM, sweep index, shared register, change counter.

## Test plan
- Reset: assert reset 2 cycles with req_valid=4'b1111 → x_out=0, change_count=0, req_ready honored only after release, first grant to requester 0.
- Single write: req_valid=4'b0001, data0=1 → req_ready=4'b0001, next edge x_out=1, change_count=1; repeat data=1 → change_count stays 1.
- Fairness: req_valid=4'b1111 held 8 cycles, alternating data → grant order 0,1,2,3,0,1,2,3; last_grant tracks.
- Sweep: x_out=0, sweep_start with sweep_len=4 and req_valid=4'b0010 → x_out 0,1,0,1 on edges t+1..t+4, change_count +3, req_ready=0 throughout, sweep_done one cycle, then requester 1 granted.
- Edges: sweep_len=0 → only sweep_done pulse, no write; CNT_W=2, 5 changing writes → change_count saturates at 3.
- Reset mid-sweep (sweep_len=10, reset at 5th write) → all outputs to reset values, no sweep_done, IDLE.
